prog_load_sequencer: RTL and testbench

- Boot-time sequencer for the single-core rv32i CPU.
- Accepts a 32-bit word stream from a host (UART/JTAG bridge) and writes it into the data BRAM, then the instruction BRAM, through their write ports.
- Holds the CPU in reset with the PC stalled during loading, then releases it for a bounded number of cycles or until halted.
- Replaces bench-driven BRAM loading; owns d_bram_init_done and pc_stall.

---
 rtl/prog_load_sequencer_if.sv | 33 +++
 rtl/prog_load_sequencer.sv | 179 +++++++++++++++++
 tb/tb_prog_load_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_load_sequencer_if.sv
// Host word stream plus the data/instruction BRAM write ports driven by the boot sequencer.
// Handshake: a word transfers on a rising clock edge where s_valid && s_ready are both 1.
interface prog_load_sequencer_if #(
    parameter int ADDR_W = 12
);
    logic              s_valid;
    logic              s_ready;
    logic [31:0]       s_data;

    logic [ADDR_W-1:0] d_w_addr;
    logic [31:0]       d_w_dat;
    logic              d_w_enb;
    logic [3:0]        d_w_byte_enb;

    logic [ADDR_W-1:0] i_w_addr;
    logic [31:0]       i_w_dat;
    logic              i_w_enb;
    logic [3:0]        i_w_byte_enb;

    modport master (
        input  s_valid, s_data,
        output s_ready,
        output d_w_addr, d_w_dat, d_w_enb, d_w_byte_enb,
        output i_w_addr, i_w_dat, i_w_enb, i_w_byte_enb
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready,
        input  d_w_addr, d_w_dat, d_w_enb, d_w_byte_enb,
        input  i_w_addr, i_w_dat, i_w_enb, i_w_byte_enb
    );
endinterface

// File: rtl/prog_load_sequencer.sv
// Boot sequencer: streams host words into data BRAM then instruction BRAM,
// then releases the rv32i core for a bounded run or until halted.
module prog_load_sequencer #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [11:0]            data_cnt_i,
    input  logic [11:0]            instr_cnt_i,
    input  logic [31:0]            run_cycles_i,
    input  logic                   halt_req_i,
    prog_load_sequencer_if.master  bus,
    output logic                   cpu_rst_o,
    output logic                   pc_stall_o,
    output logic                   d_bram_init_done_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [2:0]             state_o
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_D = 3'd1,
        LOAD_I = 3'd2,
        RUN    = 3'd3,
        HALT   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [11:0]       dcnt_q, dcnt_d, icnt_q, icnt_d, idx_q, idx_d;
    logic [31:0]       run_q, run_d, cyc_q, cyc_d;
    logic              s_ready_q, s_ready_d;
    logic [ADDR_W-1:0] d_addr_q, d_addr_d, i_addr_q, i_addr_d;
    logic [31:0]       d_dat_q, d_dat_d, i_dat_q, i_dat_d;
    logic              d_enb_q, d_enb_d, i_enb_q, i_enb_d;
    logic              cpu_rst_q, cpu_rst_d, pc_stall_q, pc_stall_d;
    logic              init_done_q, init_done_d, busy_q, busy_d;
    logic              done_q, done_d, err_q, err_d;
    logic              accept, range_bad;
    logic [ADDR_W-1:0] idx_addr;

    assign accept    = s_ready_q && bus.s_valid;
    assign range_bad = (data_cnt_i > 12'(DEPTH)) || (instr_cnt_i > 12'(DEPTH));
    assign idx_addr  = {idx_q[ADDR_W-3:0], 2'b00};

    always_comb begin
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        icnt_d   = icnt_q;
        run_d    = run_q;
        idx_d    = idx_q;
        cyc_d    = '0;
        err_d    = err_q;
        d_addr_d = d_addr_q;
        d_dat_d  = d_dat_q;
        d_enb_d  = 1'b0;
        i_addr_d = i_addr_q;
        i_dat_d  = i_dat_q;
        i_enb_d  = 1'b0;

        case (state_q)
            IDLE, HALT: begin
                if (start_i) begin
                    dcnt_d = data_cnt_i;
                    icnt_d = instr_cnt_i;
                    run_d  = run_cycles_i;
                    idx_d  = '0;
                    err_d  = range_bad;
                    if (range_bad)              state_d = HALT;
                    else if (data_cnt_i != '0)  state_d = LOAD_D;
                    else if (instr_cnt_i != '0) state_d = LOAD_I;
                    else                        state_d = RUN;
                end
            end
            LOAD_D: begin
                if (accept) begin
                    d_enb_d  = 1'b1;
                    d_addr_d = idx_addr;
                    d_dat_d  = bus.s_data;
                    if (idx_q + 12'd1 == dcnt_q) begin
                        idx_d   = '0;
                        state_d = (icnt_q == '0) ? RUN : LOAD_I;
                    end else begin
                        idx_d = idx_q + 12'd1;
                    end
                end
            end
            LOAD_I: begin
                // After the last word, s_ready is already low; spend one cycle
                // letting that write land before the core is released.
                if (accept) begin
                    i_enb_d  = 1'b1;
                    i_addr_d = idx_addr;
                    i_dat_d  = bus.s_data;
                    idx_d    = idx_q + 12'd1;
                end else if (idx_q == icnt_q) begin
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                cyc_d = cyc_q + 32'd1;
                if (halt_req_i || ((run_q != '0) && (cyc_q == run_q - 32'd1)))
                    state_d = HALT;
            end
            default: state_d = IDLE;
        endcase

        s_ready_d   = (state_d == LOAD_D) || ((state_d == LOAD_I) && (idx_d != icnt_d));
        cpu_rst_d   = (state_d == IDLE) || (state_d == LOAD_D) || (state_d == LOAD_I);
        pc_stall_d  = (state_d != RUN);
        init_done_d = (state_d == RUN) || (state_d == HALT);
        busy_d      = (state_d == LOAD_D) || (state_d == LOAD_I) || (state_d == RUN);
        done_d      = (state_d == HALT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            dcnt_q      <= '0;
            icnt_q      <= '0;
            run_q       <= '0;
            idx_q       <= '0;
            cyc_q       <= '0;
            s_ready_q   <= 1'b0;
            d_addr_q    <= '0;
            d_dat_q     <= '0;
            d_enb_q     <= 1'b0;
            i_addr_q    <= '0;
            i_dat_q     <= '0;
            i_enb_q     <= 1'b0;
            cpu_rst_q   <= 1'b1;
            pc_stall_q  <= 1'b1;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            icnt_q      <= icnt_d;
            run_q       <= run_d;
            idx_q       <= idx_d;
            cyc_q       <= cyc_d;
            s_ready_q   <= s_ready_d;
            d_addr_q    <= d_addr_d;
            d_dat_q     <= d_dat_d;
            d_enb_q     <= d_enb_d;
            i_addr_q    <= i_addr_d;
            i_dat_q     <= i_dat_d;
            i_enb_q     <= i_enb_d;
            cpu_rst_q   <= cpu_rst_d;
            pc_stall_q  <= pc_stall_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.s_ready        = s_ready_q;
    assign bus.d_w_addr       = d_addr_q;
    assign bus.d_w_dat        = d_dat_q;
    assign bus.d_w_enb        = d_enb_q;
    assign bus.d_w_byte_enb   = d_enb_q ? 4'hF : 4'h0;
    assign bus.i_w_addr       = i_addr_q;
    assign bus.i_w_dat        = i_dat_q;
    assign bus.i_w_enb        = i_enb_q;
    assign bus.i_w_byte_enb   = i_enb_q ? 4'hF : 4'h0;
    assign cpu_rst_o          = cpu_rst_q;
    assign pc_stall_o         = pc_stall_q;
    assign d_bram_init_done_o = init_done_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign err_o              = err_q;
    assign state_o            = state_q;
endmodule

// File: tb/tb_prog_load_sequencer.sv
// Randomized session bench for prog_load_sequencer with a write-list reference model.
module tb_prog_load_sequencer;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start;
  logic [11:0] data_cnt, instr_cnt;
  logic [31:0] run_cycles;
  logic        halt_req;
  logic        cpu_rst, pc_stall, init_done, busy, done, err;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [43:0] d_exp_q[$];
  logic [43:0] i_exp_q[$];

  prog_load_sequencer_if bus ();

  prog_load_sequencer dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .start_i            (start),
    .data_cnt_i         (data_cnt),
    .instr_cnt_i        (instr_cnt),
    .run_cycles_i       (run_cycles),
    .halt_req_i         (halt_req),
    .bus                (bus),
    .cpu_rst_o          (cpu_rst),
    .pc_stall_o         (pc_stall),
    .d_bram_init_done_o (init_done),
    .busy_o             (busy),
    .done_o             (done),
    .err_o              (err),
    .state_o            (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int dc, input int ic, input logic [31:0] rc);
    @(posedge clk); #1;
    start = 1'b1; data_cnt = 12'(dc); instr_cnt = 12'(ic); run_cycles = rc;
    @(posedge clk); #1;
    start = 1'b0;
    data_cnt = 12'($urandom_range(4095)); instr_cnt = 12'($urandom_range(4095));
    run_cycles = $urandom;
  endtask

  // Reset in the middle of LOAD_D after two accepted words.
  task automatic reset_mid_load();
    int acc = 0;
    int wr = 0;
    int rdy = 0;
    pulse_start(5, 3, 32'd10);
    bus.s_valid = 1'b1; bus.s_data = $urandom;
    for (int c = 0; c < 20 && acc < 2; c++) begin
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) acc++;
      @(posedge clk); #1;
      bus.s_data = $urandom;
    end
    check("rst_acc", 32'(acc), 32'd2);
    rst_ni = 1'b0;
    #1;
    check("rst_ready", 32'(bus.s_ready), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_pc_stall", 32'(pc_stall), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    repeat (4) begin
      @(negedge clk);
      if (bus.d_w_enb || bus.i_w_enb) wr++;
      if (bus.s_ready) rdy++;
    end
    @(posedge clk); #1;
    rst_ni = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.d_w_enb || bus.i_w_enb) wr++;
      if (bus.s_ready) rdy++;
    end
    check("rst_no_writes", 32'(wr), 32'd0);
    check("rst_no_ready", 32'(rdy), 32'd0);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  // One load/run session; expectations come from the word list and counts alone.
  task automatic session(input int dc, input int ic, input logic [31:0] rc,
                         input int gap, input int halt_at, input bit poke);
    logic [31:0] words[$];
    logic [43:0] e;
    bit  bad;
    int  nwords, ptr, acc_cnt, run_seen, first_run, last_i, run_bad, load_bad, rdy_seen;
    int  exp_run;
    bit  acc, poked, seen_done;
    bad = (dc > 1024) || (ic > 1024);
    nwords = (bad ? 0 : dc + ic) + 3;
    for (int k = 0; k < nwords; k++) words.push_back($urandom);
    if (!bad) begin
      for (int k = 0; k < dc; k++) d_exp_q.push_back({12'(k * 4), words[k]});
      for (int k = 0; k < ic; k++) i_exp_q.push_back({12'(k * 4), words[dc + k]});
    end
    exp_run = bad ? 0 : (halt_at >= 0 ? halt_at + 1 : int'(rc));
    ptr = 0; acc_cnt = 0; run_seen = 0; first_run = -1; last_i = -1;
    run_bad = 0; load_bad = 0; rdy_seen = 0; poked = 0; seen_done = 0;

    pulse_start(dc, ic, rc);
    bus.s_valid = ($urandom_range(99) >= 32'(gap)); bus.s_data = words[0];
    for (int cyc = 1; cyc < 5000; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        check("start_init_done", 32'(init_done), 32'(bad || (dc == 0 && ic == 0)));
        check("start_done", 32'(done), 32'(bad));
        check("start_busy", 32'(busy), 32'(!bad));
        check("start_err", 32'(err), 32'(bad));
      end
      acc = bus.s_valid && bus.s_ready;
      if (bus.s_ready) rdy_seen++;
      if (acc) acc_cnt++;
      if (bus.d_w_enb) begin
        if (d_exp_q.size() == 0) check("d_extra_write", 32'd1, 32'd0);
        else begin
          e = d_exp_q.pop_front();
          check("d_addr", 32'(bus.d_w_addr), 32'(e[43:32]));
          check("d_data", bus.d_w_dat, e[31:0]);
          check("d_be", 32'(bus.d_w_byte_enb), 32'hF);
        end
      end
      if (bus.i_w_enb) begin
        last_i = cyc;
        if (i_exp_q.size() == 0) check("i_extra_write", 32'd1, 32'd0);
        else begin
          e = i_exp_q.pop_front();
          check("i_addr", 32'(bus.i_w_addr), 32'(e[43:32]));
          check("i_data", bus.i_w_dat, e[31:0]);
          check("i_be", 32'(bus.i_w_byte_enb), 32'hF);
        end
      end
      if (!pc_stall) begin
        if (run_seen == 0) first_run = cyc;
        run_seen++;
        if (cpu_rst || !init_done || !busy) run_bad++;
      end else if (run_seen == 0 && !done) begin
        if (!cpu_rst || init_done || !busy) load_bad++;
      end
      if (done) begin
        seen_done = 1;
        break;
      end
      @(posedge clk); #1;
      if (acc) ptr++;
      if (!bus.s_valid || acc) begin
        bus.s_valid = (ptr < nwords) && ($urandom_range(99) >= 32'(gap));
        if (ptr < nwords) bus.s_data = words[ptr];
      end
      halt_req = (halt_at >= 0) && (run_seen >= halt_at);
      if (poke && !poked && ptr == 2) begin
        start = 1'b1; poked = 1;
        data_cnt = 12'($urandom_range(1, 9)); instr_cnt = 12'($urandom_range(1, 9));
      end else start = 1'b0;
    end
    check("session_timeout", 32'(seen_done), 32'd1);
    check("accepted_words", 32'(acc_cnt), 32'(bad ? 0 : dc + ic));
    check("d_missing_writes", 32'(d_exp_q.size()), 32'd0);
    check("i_missing_writes", 32'(i_exp_q.size()), 32'd0);
    check("run_length", 32'(run_seen), 32'(exp_run));
    check("run_outputs", 32'(run_bad), 32'd0);
    check("load_outputs", 32'(load_bad), 32'd0);
    if (!bad && ic > 0) check("run_after_last_i", 32'(first_run - last_i), 32'd1);
    if (!bad && dc == 0 && ic == 0) check("run_first_cycle", 32'(first_run), 32'd1);
    if (bad) check("err_ready_seen", 32'(rdy_seen), 32'd0);
    check("end_done", 32'(done), 32'd1);
    check("end_err", 32'(err), 32'(bad));
    check("end_pc_stall", 32'(pc_stall), 32'd1);
    check("end_cpu_rst", 32'(cpu_rst), 32'd0);
    check("end_init_done", 32'(init_done), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_ready", 32'(bus.s_ready), 32'd0);
    d_exp_q.delete(); i_exp_q.delete();
    @(posedge clk); #1;
    bus.s_valid = 1'b0; halt_req = 1'b0; start = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; start = 1'b0; halt_req = 1'b0;
    data_cnt = '0; instr_cnt = '0; run_cycles = '0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(bus.s_ready), 32'd0);
    check("reset_d_enb", 32'(bus.d_w_enb), 32'd0);
    check("reset_d_addr", 32'(bus.d_w_addr), 32'd0);
    check("reset_d_be", 32'(bus.d_w_byte_enb), 32'd0);
    check("reset_i_enb", 32'(bus.i_w_enb), 32'd0);
    check("reset_i_addr", 32'(bus.i_w_addr), 32'd0);
    check("reset_i_be", 32'(bus.i_w_byte_enb), 32'd0);
    check("reset_cpu_rst", 32'(cpu_rst), 32'd1);
    check("reset_pc_stall", 32'(pc_stall), 32'd1);
    check("reset_init_done", 32'(init_done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;

    reset_mid_load();
    session(5, 7, 32'd100, 0, -1, 1);
    session(3, 2, 32'd20, 40, -1, 0);
    session(0, 4, 32'd8, 20, -1, 0);
    session(0, 0, 32'd5, 0, -1, 0);
    session(2, 3, 32'd0, 10, 37, 0);
    session(1, 1025, 32'd10, 0, -1, 0);
    session(1, 2, 32'd6, 0, -1, 0);
    session(4, 0, 32'd7, 30, -1, 0);
    session(1024, 1, 32'd3, 0, -1, 0);
    for (int s = 0; s < 5; s++)
      session(int'($urandom_range(0, 8)), int'($urandom_range(0, 8)),
              32'($urandom_range(1, 20)), int'($urandom_range(0, 50)), -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
